// File: rtl/decode_stage.sv
// RV32 decode stage feeding the ID/EX boundary: handshake, flush, load-use bubble, illegal flag.
// Defining DECODE_MULDIV_EN adds M-extension (MUL/MULH/DIV/REM) decode on the OP opcode.
module decode_stage #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int ALUOP_W      = 4,
  parameter int HAZARD_CHECK = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        inst,
  input  logic [XLEN-1:0]    inst_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  readAddr1,
  output logic [REG_AW-1:0]  readAddr2,
  output logic [REG_AW-1:0]  writeAddr,
  output logic [6:0]         OutOpcode,
  output logic [2:0]         OutFunc3,
  output logic [XLEN-1:0]    immValue,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [1:0]         dataCacheControl,
  output logic               regWriteEnable,
  output logic               illegal,
  output logic [XLEN-1:0]    pc_out
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

  state_t state_q, state_d;

  logic [6:0]         opc, f7;
  logic [2:0]         f3;
  logic [3:0]         aluDec;
  logic [1:0]         cacheDec;
  logic               weDec, illDec;
  logic [XLEN-1:0]    immDec;
  logic               usesRs1, usesRs2, hazard, accept;

  logic [REG_AW-1:0]  writeAddr_q;
  logic [6:0]         opcode_q;
  logic [2:0]         func3_q;
  logic [XLEN-1:0]    imm_q, pc_q;
  logic [ALUOP_W-1:0] alu_q;
  logic [1:0]         cache_q;
  logic               we_q, ill_q;

  assign opc       = inst[6:0];
  assign f3        = inst[14:12];
  assign f7        = inst[31:25];
  assign readAddr1 = REG_AW'(inst[19:15]);
  assign readAddr2 = REG_AW'(inst[24:20]);

  function automatic logic [3:0] baseAlu(input logic [2:0] fn);
    case (fn)
      3'b000:  baseAlu = 4'd1;
      3'b001:  baseAlu = 4'd6;
      3'b010:  baseAlu = 4'd9;
      3'b011:  baseAlu = 4'd10;
      3'b100:  baseAlu = 4'd5;
      3'b101:  baseAlu = 4'd7;
      3'b110:  baseAlu = 4'd3;
      default: baseAlu = 4'd4;
    endcase
  endfunction

  always_comb begin
    aluDec   = 4'd0;
    cacheDec = 2'd0;
    weDec    = 1'b0;
    illDec   = 1'b0;
    immDec   = '0;
    case (opc)
      OPC_OPIMM: begin
        immDec = {{(XLEN-12){inst[31]}}, inst[31:20]};
        aluDec = baseAlu(f3);
        weDec  = 1'b1;
        if (f3 == 3'b001 && f7 != 7'd0) illDec = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000) aluDec = 4'd8;
          else if (f7 != 7'd0)  illDec = 1'b1;
        end
      end
      OPC_LOAD: begin
        immDec   = {{(XLEN-12){inst[31]}}, inst[31:20]};
        aluDec   = 4'd1;
        cacheDec = 2'd1;
        weDec    = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illDec = 1'b1;
      end
      OPC_STORE: begin
        immDec   = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
        aluDec   = 4'd1;
        cacheDec = 2'd2;
        if (f3[2] || f3 == 3'b011) illDec = 1'b1;
      end
      OPC_OP: begin
        weDec = 1'b1;
        if (f7 == 7'd0) aluDec = baseAlu(f3);
        else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      aluDec = 4'd2;
          else if (f3 == 3'b101) aluDec = 4'd8;
          else                   illDec = 1'b1;
        end
`ifdef DECODE_MULDIV_EN
        else if (f7 == 7'b0000001) begin
          case (f3)
            3'b000:  aluDec = 4'd12;
            3'b001:  aluDec = 4'd13;
            3'b100:  aluDec = 4'd14;
            3'b110:  aluDec = 4'd15;
            default: illDec = 1'b1;
          endcase
        end
`endif
        else illDec = 1'b1;
      end
      OPC_BRANCH: begin
        immDec = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        aluDec = 4'd2;
        if (f3 == 3'b010 || f3 == 3'b011) illDec = 1'b1;
      end
      OPC_LUI: begin
        immDec = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
        aluDec = 4'd11;
        weDec  = 1'b1;
      end
      default: illDec = 1'b1;
    endcase
    if (illDec) begin
      aluDec   = 4'd0;
      cacheDec = 2'd0;
      weDec    = 1'b0;
    end
    if (inst[11:7] == 5'd0) weDec = 1'b0;
  end

  // A held load can only be bypassed after it leaves, so stall a dependent reader one cycle.
  assign usesRs1 = (opc == OPC_OPIMM) || (opc == OPC_LOAD) || (opc == OPC_STORE) ||
                   (opc == OPC_OP) || (opc == OPC_BRANCH);
  assign usesRs2 = (opc == OPC_STORE) || (opc == OPC_OP) || (opc == OPC_BRANCH);
  assign hazard  = (HAZARD_CHECK != 0) && (state_q == FULL) && (opcode_q == OPC_LOAD) &&
                   (writeAddr_q != '0) &&
                   ((usesRs1 && readAddr1 == writeAddr_q) || (usesRs2 && readAddr2 == writeAddr_q));
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)       state_d = EMPTY;
    else if (accept) state_d = FULL;
    else begin
      case (state_q)
        FULL:    if (out_ready) state_d = (in_valid && hazard) ? BUBBLE : EMPTY;
        BUBBLE:  state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeAddr_q <= '0;
      opcode_q    <= '0;
      func3_q     <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      alu_q       <= '0;
      cache_q     <= '0;
      we_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else if (accept) begin
      writeAddr_q <= REG_AW'(inst[11:7]);
      opcode_q    <= opc;
      func3_q     <= f3;
      imm_q       <= immDec;
      pc_q        <= inst_pc;
      alu_q       <= ALUOP_W'(aluDec);
      cache_q     <= cacheDec;
      we_q        <= weDec;
      ill_q       <= illDec;
    end
  end

  assign writeAddr        = writeAddr_q;
  assign OutOpcode        = opcode_q;
  assign OutFunc3         = func3_q;
  assign immValue         = imm_q;
  assign pc_out           = pc_q;
  assign ALUop            = alu_q;
  assign dataCacheControl = cache_q;
  assign regWriteEnable   = we_q;
  assign illegal          = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps from the test plan, then random traffic
// checked against a spec-level reference model.
module tb_decode_stage;

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  cache;
    logic        we;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0, flushS = 1'b0, outReady = 1'b0;
  logic [31:0] instW = '0, instPc = '0;
  logic        inReady, outValid, regWe, illegalO;
  logic [4:0]  rA1, rA2, wA;
  logic [6:0]  opcO;
  logic [2:0]  f3O;
  logic [31:0] immO, pcO;
  logic [3:0]  aluO;
  logic [1:0]  cacheO;

  logic        inValidN = 1'b0, flushN = 1'b0, outReadyN = 1'b0;
  logic [31:0] instN = '0, instPcN = '0;
  logic        inReadyN, outValidN, regWeN, illegalN;
  logic [4:0]  rA1N, rA2N, wAN;
  logic [6:0]  opcN;
  logic [2:0]  f3N;
  logic [31:0] immN, pcN;
  logic [3:0]  aluN;
  logic [1:0]  cacheN;

  int   checks = 0;
  int   errors = 0;
  logic mHeld  = 1'b0;
  exp_t mExp   = '0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .REG_AW(5), .ALUOP_W(4), .HAZARD_CHECK(1)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .inst(instW),
    .inst_pc(instPc), .flush(flushS), .out_valid(outValid), .out_ready(outReady),
    .readAddr1(rA1), .readAddr2(rA2), .writeAddr(wA), .OutOpcode(opcO), .OutFunc3(f3O),
    .immValue(immO), .ALUop(aluO), .dataCacheControl(cacheO), .regWriteEnable(regWe),
    .illegal(illegalO), .pc_out(pcO)
  );

  decode_stage #(.XLEN(32), .REG_AW(5), .ALUOP_W(4), .HAZARD_CHECK(0)) dutNoHaz (
    .clk(clk), .rst(rst), .in_valid(inValidN), .in_ready(inReadyN), .inst(instN),
    .inst_pc(instPcN), .flush(flushN), .out_valid(outValidN), .out_ready(outReadyN),
    .readAddr1(rA1N), .readAddr2(rA2N), .writeAddr(wAN), .OutOpcode(opcN), .OutFunc3(f3N),
    .immValue(immN), .ALUop(aluN), .dataCacheControl(cacheN), .regWriteEnable(regWeN),
    .illegal(illegalN), .pc_out(pcN)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // Spec-level decode: which ALU operation each opcode/funct combination names, and its immediate.
  function automatic exp_t refDecode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   opc, fn3, fn7, imm, alu;
    bit   legal;
    int   aluTbl [8] = '{1, 6, 9, 10, 5, 7, 3, 4};
    e     = '0;
    opc   = int'(w & 32'h7F);
    fn3   = int'((w >> 12) & 32'h7);
    fn7   = int'(w >> 25);
    imm   = 0;
    alu   = 0;
    legal = 1'b1;
    e.opc = w[6:0];
    e.f3  = w[14:12];
    e.rd  = w[11:7];
    e.pc  = pc;
    case (opc)
      'h13: begin
        imm = int'(w >> 20);
        alu = aluTbl[fn3];
        if (fn3 == 1 && fn7 != 0) legal = 1'b0;
        if (fn3 == 5 && fn7 == 32) alu = 8;
        if (fn3 == 5 && fn7 != 0 && fn7 != 32) legal = 1'b0;
        e.we = 1'b1;
      end
      'h03: begin
        imm = int'(w >> 20);
        alu = 1;
        e.cache = 2'd1;
        e.we = 1'b1;
        legal = (fn3 == 0 || fn3 == 1 || fn3 == 2 || fn3 == 4 || fn3 == 5);
      end
      'h23: begin
        imm = int'(((w >> 25) << 5) | ((w >> 7) & 32'h1F));
        alu = 1;
        e.cache = 2'd2;
        legal = (fn3 <= 2);
      end
      'h33: begin
        e.we = 1'b1;
        if (fn7 == 0) alu = aluTbl[fn3];
        else if (fn7 == 32 && fn3 == 0) alu = 2;
        else if (fn7 == 32 && fn3 == 5) alu = 8;
`ifdef DECODE_MULDIV_EN
        else if (fn7 == 1 && fn3 == 0) alu = 12;
        else if (fn7 == 1 && fn3 == 1) alu = 13;
        else if (fn7 == 1 && fn3 == 4) alu = 14;
        else if (fn7 == 1 && fn3 == 6) alu = 15;
`endif
        else legal = 1'b0;
      end
      'h63: begin
        imm = int'(((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048 +
                   ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2);
        if (imm >= 4096) imm -= 8192;
        alu = 2;
        legal = (fn3 != 2 && fn3 != 3);
      end
      'h37: begin
        imm = int'(w & 32'hFFFFF000);
        alu = 11;
        e.we = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (opc == 'h13 || opc == 'h03 || opc == 'h23) begin
      if (imm >= 2048) imm -= 4096;
    end
    e.imm = 32'(imm);
    e.alu = 4'(alu);
    e.ill = !legal;
    if (!legal) begin
      e.alu   = 4'd0;
      e.cache = 2'd0;
      e.we    = 1'b0;
    end
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  function automatic bit modelReady(input logic [31:0] w, input logic ordy);
    int  opc;
    bit  r1, r2, haz;
    opc = int'(w & 32'h7F);
    r1  = (opc == 'h13 || opc == 'h03 || opc == 'h23 || opc == 'h33 || opc == 'h63);
    r2  = (opc == 'h23 || opc == 'h33 || opc == 'h63);
    haz = mHeld && mExp.opc == 7'h03 && mExp.rd != 5'd0 &&
          ((r1 && w[19:15] == mExp.rd) || (r2 && w[24:20] == mExp.rd));
    return !haz && (!mHeld || ordy);
  endfunction

  task automatic checkOutput(input logic predReady, input logic [31:0] w);
    logic [4:0] a1, a2;
    a1 = w[19:15];
    a2 = w[24:20];
    chk("in_ready", inReady, predReady);
    chk("readAddr1", rA1, a1);
    chk("readAddr2", rA2, a2);
    chk("out_valid", outValid, mHeld);
    chk("writeAddr", wA, mExp.rd);
    chk("OutOpcode", opcO, mExp.opc);
    chk("OutFunc3", f3O, mExp.f3);
    chk("immValue", immO, mExp.imm);
    chk("ALUop", aluO, mExp.alu);
    chk("dataCacheControl", cacheO, mExp.cache);
    chk("regWriteEnable", regWe, mExp.we);
    chk("illegal", illegalO, mExp.ill);
    chk("pc_out", pcO, mExp.pc);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] pc,
                               input logic fl, input logic ordy);
    logic predReady, acc;
    inValid  = v;
    instW    = w;
    instPc   = pc;
    flushS   = fl;
    outReady = ordy;
    @(negedge clk);
    predReady = modelReady(w, ordy);
    checkOutput(predReady, w);
    acc = v && predReady && !fl;
    @(posedge clk);
    if (fl) mHeld = 1'b0;
    else if (acc) begin
      mHeld = 1'b1;
      mExp  = refDecode(w, pc);
    end else if (mHeld && ordy) mHeld = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] randInst();
    logic [6:0]  opcs [8] = '{7'h13, 7'h03, 7'h23, 7'h33, 7'h63, 7'h37, 7'h7F, 7'h17};
    logic [6:0]  f7s  [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  fn3;
    f7 = f7s[$urandom_range(0, 3)];
    if ($urandom_range(0, 3) == 0) f7 = 7'($urandom);
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    fn3 = 3'($urandom);
    return {f7, rs2, rs1, fn3, rd, opcs[$urandom_range(0, 7)]};
  endfunction

  initial begin
    $display("[TB] starting decode_stage bench");
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'hFFF0E293, 32'h100, 1'b0, 1'b1);
    chk("ori_valid", outValid, 1'b1);
    chk("ori_rd", wA, 32'd5);
    chk("ori_imm", immO, 32'hFFFFFFFF);
    chk("ori_alu", aluO, 32'd3);
    chk("ori_we", regWe, 1'b1);
    chk("ori_cache", cacheO, 32'd0);

    applyStimulus(1'b1, 32'h00012183, 32'h104, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h00118233, 32'h108, 1'b0, 1'b1);
    chk("bubble_valid", outValid, 1'b0);
    applyStimulus(1'b1, 32'h00118233, 32'h108, 1'b0, 1'b1);
    chk("add_valid", outValid, 1'b1);
    chk("add_alu", aluO, 32'd1);

    applyStimulus(1'b1, 32'h00512423, 32'h10C, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hFFF0E293, 32'h110, 1'b0, 1'b0);
    chk("sw_imm", immO, 32'd8);
    chk("sw_cache", cacheO, 32'd2);
    chk("sw_we", regWe, 1'b0);
    chk("sw_stall_ready", inReady, 1'b0);
    applyStimulus(1'b1, 32'hFFF0E293, 32'h110, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h00118233, 32'h200, 1'b1, 1'b1);
    chk("flush_valid", outValid, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    applyStimulus(1'b1, 32'h0000007F, 32'h300, 1'b0, 1'b1);
    chk("bad_opc_illegal", illegalO, 1'b1);
    chk("bad_opc_valid", outValid, 1'b1);
    applyStimulus(1'b1, 32'h02208033, 32'h304, 1'b0, 1'b1);
`ifdef DECODE_MULDIV_EN
    chk("mul_illegal", illegalO, 1'b0);
    chk("mul_alu", aluO, 32'd12);
`else
    chk("mul_illegal", illegalO, 1'b1);
    chk("mul_alu", aluO, 32'd0);
`endif
    chk("mul_we", regWe, 1'b0);

    applyStimulus(1'b1, 32'h00012183, 32'h400, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_valid", outValid, 1'b0);
    chk("rst_imm", immO, 32'd0);
    chk("rst_alu", aluO, 32'd0);
    chk("rst_rd", wA, 32'd0);
    chk("rst_pc", pcO, 32'd0);
    mHeld = 1'b0;
    mExp  = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    inValid   = 1'b0;
    flushS    = 1'b1;
    inValidN  = 1'b1;
    instN     = 32'h00012183;
    outReadyN = 1'b1;
    @(posedge clk);
    #1;
    chk("nohaz_lw_valid", outValidN, 1'b1);
    instN = 32'h00118233;
    @(negedge clk);
    chk("nohaz_ready", inReadyN, 1'b1);
    @(posedge clk);
    #1;
    chk("nohaz_add_valid", outValidN, 1'b1);
    chk("nohaz_add_alu", aluN, 32'd1);
    chk("nohaz_add_rd", wAN, 32'd4);
    inValidN = 1'b0;
    mHeld    = 1'b0;

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), randInst(), $urandom,
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor to the combinational decode/control pair.
- Decodes one RV32 instruction per cycle into operand addresses, a sign-extended immediate and control fields, and holds them in an output register that feeds the ID/EX boundary.
- Adds a valid/ready handshake, flush, load-use hazard bubble insertion and illegal-instruction flagging.
- Sits between the IF/ID register and the ALU stage.

Parameters:
- XLEN, 32, datapath and immediate width; sign-extension target; ≥32.
- REG_AW, 5, register address width.
- ALUOP_W, 4, ALUop field width.
- HAZARD_CHECK, 1, 1 = load-use bubble logic present; 0 = never stall on hazard.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  IF/ID presents an instruction.
- in_ready  out  1  stage accepts inst this cycle.
- inst  in  32  instruction word.
- inst_pc  in  XLEN  PC of inst.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  output register holds a real instruction.
- out_ready  in  1  downstream accepts.
- readAddr1, readAddr2  out  REG_AW  rs1/rs2, combinational from inst, for register file.
- writeAddr  out  REG_AW  rd (registered).
- OutOpcode  out  7 ; OutFunc3  out  3  registered fields.
- immValue  out  XLEN  sign-extended immediate (registered).
- ALUop  out  ALUOP_W ; dataCacheControl  out  2 ; regWriteEnable  out  1 ; illegal  out  1.
- pc_out  out  XLEN  registered inst_pc.

Behaviour:
- Reset: all registered outputs 0, out_valid=0, state EMPTY. Reset is honoured mid-transfer; no partial state survives.
- Accept condition: in_valid && in_ready. in_ready = !stall && (!out_valid || out_ready).
- Latency: 1 cycle, accept to out_valid.
- Output register holds its value while out_valid && !out_ready.
- States:
  - EMPTY: no held instruction.
  - FULL: out_valid=1.
  - BUBBLE: one-cycle hazard stall.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept with out_ready.
  - FULL→EMPTY on out_ready without accept.
  - FULL→BUBBLE when a hazard is detected and out_ready.
  - BUBBLE→FULL on the next accept; the held load has left, so the hazard clears.
- Load-use hazard: held instruction is LOAD, writeAddr≠0, and the incoming instruction reads that register.
  - rs1 read by OP-IMM, LOAD, STORE, OP, BRANCH.
  - rs2 read by STORE, OP, BRANCH.
  - Response: in_ready=0, out_valid=0 for exactly one cycle. No bubble if HAZARD_CHECK=0.
- Flush: next edge sets out_valid=0, state EMPTY, no accept that cycle. Flush wins over simultaneous accept and over a hazard.
- Immediates, sign-extended from the top bit to XLEN:
  - I-type: inst[31:20].
  - S-type: {inst[31:25],inst[11:7]}.
  - B-type: {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - U-type: {inst[31:12],12'b0}.
  - Otherwise 0.
- ALUop encoding: 0 NOP, 1 ADD, 2 SUB, 3 OR, 4 AND, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 PASSB.
- Opcode decode:
  - OP-IMM 0010011: by funct3; SRAI when inst[30]; regWE=1.
  - LOAD 0000011: ADD, cache READ(1), regWE=1.
  - STORE 0100011: ADD, cache WRITE(2), regWE=0.
  - OP 0110011: funct7 0000000 or 0100000 (SUB/SRA); regWE=1.
  - BRANCH 1100011: SUB, regWE=0.
  - LUI 0110111: PASSB, regWE=1.
- rd=0 forces regWriteEnable=0.
- Any other opcode, an undefined funct3, or an undefined funct7 sets illegal=1, ALUop=0, regWE=0, cache NOP(0). The instruction still flows with out_valid=1.

Optional Feature:
- Macro: DECODE_MULDIV_EN.
- Defined: OP with funct7=0000001 decodes to ALUop 12 MUL, 13 MULH, 14 DIV, 15 REM (funct3 000, 001, 100, 110); other M funct3 values are illegal.
- Undefined: funct7=0000001 is illegal. The ALUOP_W=4 encoding is unchanged.

Test Plan:
- Reset asserted mid-FULL (holding 0x00012183) → immediately out_valid=0, immValue=0, ALUop=0, in_ready=1 after release.
- inst 0xFFF0E293 (ori x5,x1,-1) → next cycle out_valid=1, writeAddr=5, immValue=0xFFFFFFFF, ALUop=3, regWE=1, cache=0.
- 0x00012183 (lw x3,0(x2)) then 0x00118233 (add x4,x3,x1) back-to-back, out_ready=1 → one cycle with in_ready=0/out_valid=0; add emerges the following cycle with ALUop=1. With HAZARD_CHECK=0 → no bubble.
- 0x00512423 (sw x5,8(x2)) with out_ready=0 for 3 cycles → outputs stable; immValue=8, cache=2, regWE=0, in_ready=0 until drain.
- flush asserted in the same cycle as in_valid with 0x00118233 → next cycle out_valid=0, instruction dropped, state EMPTY.
- 0x0000007F, then 0x02208033 (mul x0 form, funct7=0000001) → illegal=1 for both without DECODE_MULDIV_EN; with it, second gives ALUop=12, illegal=0, regWE=0 (rd=0).
